// File: rtl/dff_fetch_pkg.sv
// Shared IF/ID pipeline definitions: datapath width and fetch-bundle field layout.
package dff_fetch_pkg;

  localparam int XLEN           = 32;
  localparam int IF_ID_W        = 2 * XLEN;
  localparam int IF_ID_INST_LSB = 0;
  localparam int IF_ID_PC_LSB   = XLEN;

  // Fetch bundle layout is {pc, inst}; the register itself never looks inside.
  function automatic logic [IF_ID_W-1:0] pack_if_id(input logic [XLEN-1:0] pc,
                                                    input logic [XLEN-1:0] inst);
    logic [IF_ID_W-1:0] bundle;
    bundle = '0;
    bundle[IF_ID_PC_LSB   +: XLEN] = pc;
    bundle[IF_ID_INST_LSB +: XLEN] = inst;
    return bundle;
  endfunction

endpackage

// File: rtl/dff_fetch.sv
// IF/ID pipeline register: loads the opaque fetch bundle on enabled edges, holds on stall.
module dff_fetch
  import dff_fetch_pkg::*;
#(
  parameter int N = IF_ID_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q
);

  // Active-low asynchronous clear takes priority over any coincident enabled edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Q <= '0;
    end else if (en) begin
      Q <= D;
    end
  end

endmodule

// File: tb/tb_dff_fetch.sv
// Self-checking bench for dff_fetch: vector table, hand-written corner sequences, random vs model.
module tb_dff_fetch;
  import dff_fetch_pkg::*;

  logic               clk;
  logic               rst;
  logic               en;
  logic [IF_ID_W-1:0] D;
  logic [IF_ID_W-1:0] Q;

  int assert_count = 0;
  int fail_count   = 0;

  typedef struct {
    string              name;
    logic               rst;
    logic               en;
    logic [IF_ID_W-1:0] d;
    logic [IF_ID_W-1:0] q;
  } vec_t;

  vec_t vecs[10];

  dff_fetch #(.N(IF_ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .D   (D),
    .Q   (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [IF_ID_W-1:0] actual,
                              input logic [IF_ID_W-1:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive at the falling edge, confirm nothing leaks before the rising edge, then check after it.
  task automatic apply_stimulus(input string name, input logic r, input logic e,
                                input logic [IF_ID_W-1:0] d, input logic [IF_ID_W-1:0] prev_q,
                                input logic [IF_ID_W-1:0] exp_q);
    @(negedge clk);
    rst = r;
    en  = e;
    D   = d;
    #1;
    check_output({name, "_pre"}, Q, r ? prev_q : '0);
    @(posedge clk);
    #1;
    check_output({name, "_post"}, Q, exp_q);
  endtask

  initial begin
    logic [IF_ID_W-1:0] model_q;
    logic [IF_ID_W-1:0] prev_q;
    logic               r_rand;
    logic               e_rand;
    logic [IF_ID_W-1:0] d_rand;

    rst = 1'b0;
    en  = 1'b0;
    D   = '0;
    #1;
    check_output("reset_initial", Q, '0);

    vecs[0] = '{"rst_hold0", 1'b0, 1'b1, pack_if_id(32'hFFFF_FFFF, 32'd10), 64'h0};
    vecs[1] = '{"rst_hold1", 1'b0, 1'b1, pack_if_id(32'hFFFF_FFFF, 32'd10), 64'h0};
    vecs[2] = '{"rst_hold2", 1'b0, 1'b1, pack_if_id(32'hFFFF_FFFF, 32'd10), 64'h0};
    vecs[3] = '{"load_a",    1'b1, 1'b1, pack_if_id(32'hFFFF_FFFF, 32'd10), 64'hFFFF_FFFF_0000_000A};
    vecs[4] = '{"load_b",    1'b1, 1'b1, pack_if_id(32'd5, 32'd50),         64'h0000_0005_0000_0032};
    vecs[5] = '{"load_c",    1'b1, 1'b1, pack_if_id(32'd10, 32'd10),        64'h0000_000A_0000_000A};
    vecs[6] = '{"stall0",    1'b1, 1'b0, pack_if_id(32'd20, 32'd21),        64'h0000_000A_0000_000A};
    vecs[7] = '{"stall1",    1'b1, 1'b0, 64'hDEAD_BEEF_CAFE_F00D,           64'h0000_000A_0000_000A};
    vecs[8] = '{"stall2",    1'b1, 1'b0, pack_if_id(32'd20, 32'd21),        64'h0000_000A_0000_000A};
    vecs[9] = '{"resume",    1'b1, 1'b1, pack_if_id(32'd20, 32'd21),        64'h0000_0014_0000_0015};

    prev_q = '0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].name, vecs[i].rst, vecs[i].en, vecs[i].d, prev_q, vecs[i].q);
      prev_q = vecs[i].q;
    end

    // Asynchronous clear in the middle of a cycle, no clock edge involved.
    apply_stimulus("async_setup", 1'b1, 1'b1, 64'h0000_0005_0000_0032, prev_q,
                   64'h0000_0005_0000_0032);
    #2;
    rst = 1'b0;
    #1;
    check_output("async_clear", Q, '0);

    // Release between edges must not load; the next rising edge does.
    @(negedge clk);
    en = 1'b1;
    D  = 64'h1234;
    #2;
    rst = 1'b1;
    #1;
    check_output("release_no_load", Q, '0);
    @(posedge clk);
    #1;
    check_output("release_first_load", Q, 64'h1234);

    // Reset arriving on the same timestep as an enabled edge still wins.
    @(negedge clk);
    D = 64'h0BAD_F00D_0000_0001;
    @(posedge clk);
    rst = 1'b0;
    #1;
    check_output("reset_priority", Q, '0);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check_output("reset_priority_hold", Q, '0);

    // Random traffic against a register-level reference: load when enabled, hold otherwise.
    model_q = '0;
    for (int i = 0; i < 300; i++) begin
      r_rand = ($urandom_range(0, 15) != 0);
      e_rand = ($urandom_range(0, 2) != 0);
      d_rand = {$urandom, $urandom};
      @(negedge clk);
      rst = r_rand;
      en  = e_rand;
      D   = d_rand;
      if (!r_rand) model_q = '0;
      #1;
      check_output("rand_pre", Q, model_q);
      @(posedge clk);
      if (r_rand && e_rand) model_q = d_rand;
      #1;
      check_output("rand_post", Q, model_q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/dff_fetch.md
Name: dff_fetch

Overview:
- Fetch-stage pipeline register (IF/ID boundary) with enable.
- Captures the N-bit fetch bundle D on the rising clock edge when enabled, and presents it as Q to the decode stage.
- Default packing, N=64: D[63:32] = selected PC value (PC-mux output), D[31:0] = fetched instruction word.
- The block treats D as opaque. It never interprets the fields.

Parameters:
- N, 64, total register width in bits; must be ≥1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- en  input  1  load enable, active-high; 0 = stall/hold.
- D  input  N  next fetch bundle ({pc[31:0], inst[31:0]} at N=64).
- Q  output  N  registered fetch bundle to decode.

Behaviour:
- Reset:
  - rst=0 forces Q to all-zeros immediately, independent of clk and en.
  - Q stays zero while rst=0. Clock edges and en are ignored during reset.
- Release:
  - Deassertion of rst (0→1) does not itself change Q.
  - The first load occurs at the first rising clk edge with rst=1 and en=1.
- Load: at each rising clk edge with rst=1 and en=1, Q takes the value D had just before the edge.
  - Latency is one clock edge from D to Q.
- Hold: at a rising clk edge with rst=1 and en=0, Q keeps its previous value.
  - Changes on D while en=0 are never visible on Q.
- Q is a pure register output. There is no combinational path from D or en to Q.
- Simultaneous events:
  - rst=0 coinciding with a clk edge and en=1: reset wins, Q=0.
  - en toggling between edges has no effect; only its value at the edge matters.
  - D changing between edges has no effect until the next enabled edge.
- Reset mid-operation: Q clears within the same delta regardless of pending data. Previously loaded data is lost.
- X-handling:
  - After reset release, Q is never X unless an X on D was loaded with en=1.
  - An X on en at a clock edge makes Q X (no masking required).
- Width rule: all N bits are loaded and held together. There are no per-field enables.
- No internal state other than the N-bit register.

Decomposition:
- Shared pipeline package:
  - XLEN=32.
  - IF_ID_W = 2*XLEN (=64).
  - Field offsets: IF_ID_INST_LSB=0, IF_ID_PC_LSB=32.
- Instantiate the block with N=IF_ID_W.
- No sub-module. A single always block with the asynchronous active-low reset and enable is natural.
- The same module is reusable for the other pipeline registers by changing N.

Test Plan:
- Reset hold: rst=0, en=1, D=64'hFFFF_FFFF_0000_000A over several clk edges → Q=64'h0 throughout.
- Asynchronous reset: Q=64'h0000_0005_0000_0032; drop rst to 0 mid-cycle (no clk edge) → Q=0 immediately.
- Load: rst=1, en=1, D={32'hFFFF_FFFF, 32'd10} → Q=64'hFFFF_FFFF_0000_000A after the next rising edge; unchanged before it. Then D={32'd5, 32'd50} → Q=64'h0000_0005_0000_0032 one edge later.
- Stall: Q=64'h0000_000A_0000_000A; set en=0, change D to {32'd20, 32'd21} across several edges → Q unchanged. Re-raise en=1 → Q=64'h0000_0014_0000_0015 at the next edge.
- Release timing: rst 0→1 between edges with en=1, D=64'h1234 → Q stays 0 until the next rising edge, then Q=64'h1234.
- Reset priority: rst=0 asserted at the same time as a clk edge, with en=1 and D nonzero → Q=0. Random D/en sequence against a reference model → Q matches every cycle.
